// File: rtl/wb_cyc_arbiter.sv
// wb_cyc_arbiter: two-master WISHBONE CYC arbiter.
//   m0 (PCI bridge WB master) is gated to the test slave, m1 (test WB master)
//   is gated to the bridge slave. At most one gated CYC is ever active, and
//   every change of owner passes through at least one IDLE cycle.
//   Ties go to m0 (RR_EN=0) or to the master not granted last (RR_EN=1).
//   Optional feature macro: WB_ARB_TIMEOUT_EN enables a stuck-cycle watchdog
//   that force-releases a grant after TIMEOUT ack-less cycles. The arbiter
//   then parks in LOCKOUT until the stuck master drops CYC.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   m0_cyc_i, m1_cyc_i      CYC requests from the two masters
//   s0_ack_i, s1_ack_i      slave acks returned to m0 / m1
//   m0_gnt_o, m1_gnt_o      gated CYC to the test slave / bridge slave
//   busy_o                  grant active or arbiter in LOCKOUT
//   last_gnt_o              index of the most recently granted master
//   gnt0_cnt_o, gnt1_cnt_o  saturating grant counters
//   timeout_o               one-cycle pulse on a watchdog release
module wb_cyc_arbiter #(
  parameter logic        RR_EN   = 1'b0,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m1_cyc_i,
  input  logic             s0_ack_i,
  input  logic             s1_ack_i,
  output logic             m0_gnt_o,
  output logic             m1_gnt_o,
  output logic             busy_o,
  output logic             last_gnt_o,
  output logic [CNT_W-1:0] gnt0_cnt_o,
  output logic [CNT_W-1:0] gnt1_cnt_o,
  output logic             timeout_o
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2, LOCKOUT = 2'd3} state_t;
  localparam int unsigned WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;
  // Acks and TIMEOUT only matter to the watchdog.
  logic unused_wd_inputs;
  assign unused_wd_inputs = ^{s0_ack_i, s1_ack_i, 32'(TIMEOUT)};
`endif

  state_t           state_q, state_d;
  logic             last_d;
  logic [CNT_W-1:0] cnt0_d, cnt1_d;
  logic             to_d;
  logic             take1;
  logic             own_cyc;
  logic             own_ack;

  // The current (or stuck) owner is always the last granted master.
  assign own_cyc = last_gnt_o ? m1_cyc_i : m0_cyc_i;
  assign own_ack = last_gnt_o ? s1_ack_i : s0_ack_i;

  // Next-state, counter and watchdog logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_gnt_o;
    cnt0_d  = gnt0_cnt_o;
    cnt1_d  = gnt1_cnt_o;
    to_d    = 1'b0;
    take1   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          if (m0_cyc_i && m1_cyc_i) take1 = RR_EN & ~last_gnt_o;
          else                      take1 = m1_cyc_i;
          state_d = take1 ? G1 : G0;
          last_d  = take1;
          if (take1) begin
            if (!(&gnt1_cnt_o)) cnt1_d = gnt1_cnt_o + CNT_W'(1);
          end else begin
            if (!(&gnt0_cnt_o)) cnt0_d = gnt0_cnt_o + CNT_W'(1);
          end
`ifdef WB_ARB_TIMEOUT_EN
          wd_d = '0;
`endif
        end
      end
      G0, G1: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (own_ack) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = LOCKOUT;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      LOCKOUT: begin
        if (!own_cyc) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      m0_gnt_o   <= 1'b0;
      m1_gnt_o   <= 1'b0;
      busy_o     <= 1'b0;
      last_gnt_o <= 1'b1;
      gnt0_cnt_o <= '0;
      gnt1_cnt_o <= '0;
      timeout_o  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      m0_gnt_o   <= (state_d == G0);
      m1_gnt_o   <= (state_d == G1);
      busy_o     <= (state_d != IDLE);
      last_gnt_o <= last_d;
      gnt0_cnt_o <= cnt0_d;
      gnt1_cnt_o <= cnt1_d;
      timeout_o  <= to_d;
`ifdef WB_ARB_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

endmodule
